// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline hazard, stall and redirect controller
// Freeze on data-memory stall, load-use bubbles, fetch-stall bubbles and branch redirects.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_access,
  input  logic             dmem_resp,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_load,
  output logic             id_ex_flush,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             redir_valid,
  output logic [31:0]      redir_target,
  output logic             fetch_squash,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_REDIR_WAIT = 2'd1,
    ST_REDIR_HOLD = 2'd2,
    ST_ILLEGAL    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state;
  state_t      state_nxt;
  logic [31:0] target_q;
  logic        dstall;
  logic        istall;
  logic        lu_haz;
  logic        capture_target;

  assign dstall = dmem_access & ~dmem_resp;
  assign istall = imem_read & ~imem_resp;
  assign lu_haz = ex_mem_read & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // A taken branch that cannot redirect yet (fetch outstanding) parks its target here.
  assign capture_target = (state == ST_RUN) & ~dstall & ex_br_taken & istall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (capture_target) state_nxt = ST_REDIR_WAIT;
      end
      ST_REDIR_WAIT: begin
        if (imem_resp) state_nxt = dstall ? ST_REDIR_HOLD : ST_RUN;
      end
      ST_REDIR_HOLD: begin
        if (!dstall) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_load   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_load  = 1'b0;
    mem_wb_load  = 1'b0;
    redir_valid  = 1'b0;
    redir_target = target_q;
    fetch_squash = 1'b0;
    if (rst) begin
      case (state)
        ST_RUN: begin
          if (!dstall) begin
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if (ex_br_taken) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              if (!istall) begin
                pc_load      = 1'b1;
                redir_valid  = 1'b1;
                redir_target = ex_br_target;
              end
            end else if (lu_haz) begin
              id_ex_flush = 1'b1;
            end else if (istall) begin
              if_id_flush = 1'b1;
              id_ex_load  = 1'b1;
            end else begin
              pc_load    = 1'b1;
              if_id_load = 1'b1;
              id_ex_load = 1'b1;
            end
          end
        end
        ST_REDIR_WAIT: begin
          // The returning fetch belongs to the wrong path; drop it even while frozen.
          fetch_squash = imem_resp;
          if (!dstall) begin
            if_id_flush = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            pc_load     = imem_resp;
            redir_valid = imem_resp;
          end
        end
        ST_REDIR_HOLD: begin
          if (!dstall) begin
            pc_load     = 1'b1;
            redir_valid = 1'b1;
            if_id_flush = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_q <= 32'd0;
    end else if (capture_target) begin
      target_q <= ex_br_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_load && (state != ST_ILLEGAL) && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (redir_valid && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning width of the saturating performance counters.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, rising edge; rst  in  1  asynchronous reset, active-low.
REQ-003 SHALL have imem_read  in  1  IF has a fetch outstanding; imem_resp  in  1  fetch data valid this cycle.
REQ-004 SHALL have dmem_access  in  1  MEM stage load/store; dmem_resp  in  1  data access complete this cycle.
REQ-005 SHALL have id_rs1, id_rs2  in  5 each  ID source registers; id_use_rs1, id_use_rs2  in  1 each  source is read.
REQ-006 SHALL have ex_rd  in  5  EX destination; ex_mem_read  in  1  EX holds a load.
REQ-007 SHALL have ex_br_taken  in  1  EX resolved taken branch/jump; ex_br_target  in  32  its target.
REQ-008 SHALL have pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush, ex_mem_load, mem_wb_load  out  1 each  pipeline register enables/bubble inserts.
REQ-009 SHALL have redir_valid  out  1  PC takes redir_target; redir_target  out  32; fetch_squash  out  1  discard returning fetch.
REQ-010 SHALL have ctrl_state  out  2  FSM state; stall_cnt  out  CNT_W; flush_cnt  out  CNT_W.

Function
REQ-011 SHALL define dstall = dmem_access & ~dmem_resp; istall = imem_read & ~imem_resp; lu_haz = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-012 SHALL implement FSM RUN=0, REDIR_WAIT=1, REDIR_HOLD=2; encoding 3 unreachable, recovers to RUN next cycle.
REQ-013 SHALL, all states, with dstall: drive every *_load, *_flush, redir_valid low (full freeze); stall takes priority over all other events.
REQ-014 SHALL in RUN, no dstall, ex_br_taken, ~istall: pc_load=1, redir_valid=1, redir_target=ex_br_target (same cycle), if_id_flush=1, id_ex_flush=1, ex_mem_load=mem_wb_load=1; stay RUN.
REQ-015 SHALL in RUN, no dstall, ex_br_taken, istall: capture ex_br_target into target register, if_id_flush=1, id_ex_flush=1, pc_load=0, back end loads; go REDIR_WAIT.
REQ-016 SHALL in RUN, no dstall, no branch, lu_haz: pc_load=0, if_id_load=0, id_ex_flush=1, ex_mem_load=mem_wb_load=1.
REQ-017 SHALL in RUN, no dstall/branch/lu_haz, istall: pc_load=0, if_id_flush=1, id_ex_load, ex_mem_load, mem_wb_load=1.
REQ-018 SHALL in RUN otherwise: all *_load=1, all *_flush=0.
REQ-019 SHALL in REDIR_WAIT: pc_load=0, if_id_flush=1, back end loads (unless dstall); on imem_resp assert fetch_squash=1 (even under dstall); then ~dstall -> pc_load=1, redir_valid=1, redir_target=saved target, go RUN; dstall -> REDIR_HOLD.
REQ-020 SHALL in REDIR_HOLD: when ~dstall assert pc_load=1, redir_valid=1, redir_target=saved, if_id_flush=1, go RUN; else hold.
REQ-021 SHALL ignore ex_br_taken and lu_haz in REDIR_WAIT/REDIR_HOLD (EX/ID already flushed).
REQ-022 SHALL assert fetch_squash only per REQ-019; at most one cycle per redirect.
REQ-023 SHALL increment stall_cnt each cycle pc_load=0 and state RUN/REDIR_*; flush_cnt once per redirect (at redir_valid); both saturate at all-ones.
REQ-024 SHALL drive redir_target = saved target register whenever redir_valid=0.

Reset
REQ-025 SHALL, while rst=0, asynchronously force ctrl_state=RUN, target register=0, stall_cnt=0, flush_cnt=0, and drive all load/flush/redir_valid/fetch_squash outputs low.
REQ-026 SHALL, on rst deassertion, resume in RUN on the next rising clk; reset mid-REDIR_* discards the pending redirect.

Verification
REQ-027 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_load=0, if_id_load=0, id_ex_flush=1 one cycle; ex_rd=0 same -> no stall.
REQ-028 Branch in RUN: ex_br_taken=1, target 0x0000_0040, no stalls -> same cycle pc_load=1, redir_valid=1, redir_target=0x40, if_id_flush=id_ex_flush=1; flush_cnt=1.
REQ-029 Branch under icache miss: istall 3 cycles with branch at cycle 1 (target 0x80) -> REDIR_WAIT; on imem_resp fetch_squash=1, redir_target=0x80, back to RUN.
REQ-030 Redirect vs dmem stall: in REDIR_WAIT, imem_resp with dstall for 2 cycles -> fetch_squash once, REDIR_HOLD, redir_valid only when dmem_resp=1.
REQ-031 dstall+branch in RUN: dstall 4 cycles, ex_br_taken held -> all enables low 4 cycles, redirect on 5th; stall_cnt=4.
REQ-032 Reset mid-REDIR_WAIT: rst low asynchronously -> ctrl_state=0, counters 0, outputs low immediately; saturation: preload near max, counter stops at all-ones.
